// File: rtl/dcm_lock_supervisor.sv
// dcm_lock_supervisor: per-channel DCM lock timeout, reset-pulse retry and lock debounce supervisor
// ports: input_clk/reset (async, active-high); dcm_locked raw LOCKED in; channel_enable, clear_fault per channel;
//        dcm_reset, locked_stable, fault per channel; all_locked_stable over enabled channels; retry_count 4 bits per channel
module dcm_lock_supervisor #(
  parameter int NUM_CHANNELS       = 3,
  parameter int TIMEOUT_CYCLES     = 50000,
  parameter int RESET_PULSE_CYCLES = 10,
  parameter int STABLE_CYCLES      = 1024,
  parameter int MAX_RETRIES        = 7,
  parameter int TIMER_WIDTH        = 17
) (
  input  logic                      input_clk,
  input  logic                      reset,
  input  logic [NUM_CHANNELS-1:0]   dcm_locked,
  input  logic [NUM_CHANNELS-1:0]   channel_enable,
  input  logic [NUM_CHANNELS-1:0]   clear_fault,
  output logic [NUM_CHANNELS-1:0]   dcm_reset,
  output logic [NUM_CHANNELS-1:0]   locked_stable,
  output logic [NUM_CHANNELS-1:0]   fault,
  output logic                      all_locked_stable,
  output logic [4*NUM_CHANNELS-1:0] retry_count
);
  typedef enum logic [2:0] {DISABLED, WAIT_LOCK, RESET_PULSE, VERIFY, LOCKED, FAULT} state_t;
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] PULSE_LAST   = TIMER_WIDTH'(RESET_PULSE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] STABLE_LAST  = TIMER_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [3:0]             RETRY_LIMIT  = 4'(MAX_RETRIES);
  logic [NUM_CHANNELS-1:0] sync_meta, sync_lock;
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_lock <= '0;
    end else begin
      sync_meta <= dcm_locked;
      sync_lock <= sync_meta;
    end
  end
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) all_locked_stable <= 1'b0;
    else all_locked_stable <= (|channel_enable) & (&(locked_stable | ~channel_enable));
  end
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    state_t state, state_n;
    logic [TIMER_WIDTH-1:0] timer, timer_n;
    logic [3:0] retries, retries_n;
    logic rst_q, stable_q, fault_q;
    always_comb begin
      state_n   = state;
      timer_n   = timer + 1'b1;
      retries_n = retries;
      if (!channel_enable[c]) begin
        state_n   = DISABLED;
        timer_n   = '0;
        retries_n = '0;
      end else begin
        case (state)
          DISABLED: begin
            state_n = WAIT_LOCK;
            timer_n = '0;
          end
          WAIT_LOCK: begin
            if (sync_lock[c]) begin
              state_n = VERIFY;
              timer_n = '0;
            end else if (timer == TIMEOUT_LAST) begin
              timer_n = '0;
              if (MAX_RETRIES != 0 && retries == RETRY_LIMIT) state_n = FAULT;
              else begin
                state_n   = RESET_PULSE;
                retries_n = (retries == 4'hf) ? retries : retries + 4'd1;
              end
            end
          end
          RESET_PULSE: begin
            state_n = (timer == PULSE_LAST) ? WAIT_LOCK : RESET_PULSE;
            timer_n = (timer == PULSE_LAST) ? '0 : timer + 1'b1;
          end
          VERIFY: begin
            state_n = !sync_lock[c] ? WAIT_LOCK : (timer == STABLE_LAST) ? LOCKED : VERIFY;
            timer_n = (!sync_lock[c] || timer == STABLE_LAST) ? '0 : timer + 1'b1;
          end
          LOCKED: begin
            state_n = sync_lock[c] ? LOCKED : WAIT_LOCK;
            timer_n = '0;
          end
          FAULT: begin
            state_n   = clear_fault[c] ? WAIT_LOCK : FAULT;
            retries_n = clear_fault[c] ? 4'd0 : retries;
            timer_n   = '0;
          end
          default: begin
            state_n = WAIT_LOCK;
            timer_n = '0;
          end
        endcase
      end
    end
    // outputs are registered from the next state so they change on the same edge as the state
    always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
        state    <= WAIT_LOCK;
        timer    <= '0;
        retries  <= '0;
        rst_q    <= 1'b0;
        stable_q <= 1'b0;
        fault_q  <= 1'b0;
      end else begin
        state    <= state_n;
        timer    <= timer_n;
        retries  <= retries_n;
        rst_q    <= state_n == RESET_PULSE;
        stable_q <= state_n == LOCKED;
        fault_q  <= state_n == FAULT;
      end
    end
    assign dcm_reset[c]         = rst_q;
    assign locked_stable[c]     = stable_q;
    assign fault[c]             = fault_q;
    assign retry_count[4*c +: 4] = retries;
  end
endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// tb_dcm_lock_supervisor: directed self-checking bench for dcm_lock_supervisor
module tb_dcm_lock_supervisor;
  logic input_clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] dcm_locked = '0;
  logic [2:0] channel_enable = 3'b111;
  logic [2:0] clear_fault = '0;
  logic [2:0] dcm_reset, locked_stable, fault;
  logic all_locked_stable;
  logic [11:0] retry_count;
  int total = 0;
  int passed = 0;
  int cyc = 0;
  dcm_lock_supervisor #(
    .NUM_CHANNELS(3), .TIMEOUT_CYCLES(20), .RESET_PULSE_CYCLES(3),
    .STABLE_CYCLES(8), .MAX_RETRIES(2), .TIMER_WIDTH(17)
  ) dut (
    .input_clk(input_clk), .reset(reset), .dcm_locked(dcm_locked),
    .channel_enable(channel_enable), .clear_fault(clear_fault),
    .dcm_reset(dcm_reset), .locked_stable(locked_stable), .fault(fault),
    .all_locked_stable(all_locked_stable), .retry_count(retry_count)
  );
  always #5 input_clk = ~input_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask
  task automatic go_to(input int target);
    while (cyc < target) begin
      @(posedge input_clk);
      #1;
      cyc++;
    end
  endtask
  task automatic release_reset();
    @(posedge input_clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask
  function automatic logic [31:0] all_outs();
    return {11'd0, dcm_reset, locked_stable, fault, all_locked_stable, retry_count};
  endfunction
  initial begin
    #2;
    dcm_locked = 3'b111;
    #1;
    check("outs_in_reset", all_outs(), 32'd0);
    dcm_locked = '0;
    @(posedge input_clk);
    release_reset();
    check("outs_after_release", all_outs(), 32'd0);
    go_to(1);
    dcm_locked = 3'b101;
    go_to(6);
    dcm_locked[2] = 1'b0;
    go_to(7);
    dcm_locked[2] = 1'b1;
    go_to(11);
    check("ls0_before", locked_stable[0], 1'b0);
    go_to(12);
    check("ls0_rise", locked_stable[0], 1'b1);
    check("ls2_glitch_hold", locked_stable[2], 1'b0);
    check("dr0_never", dcm_reset[0], 1'b0);
    check("retry0_zero", retry_count[3:0], 4'd0);
    check("all_ch1_unlocked", all_locked_stable, 1'b0);
    go_to(17);
    check("ls2_before", locked_stable[2], 1'b0);
    go_to(18);
    check("ls2_rise", locked_stable[2], 1'b1);
    go_to(19);
    check("dr1_before_to", dcm_reset[1], 1'b0);
    go_to(20);
    check("dr1_pulse1", dcm_reset[1], 1'b1);
    check("retry1_one", retry_count[7:4], 4'd1);
    go_to(22);
    check("dr1_pulse1_end", dcm_reset[1], 1'b1);
    go_to(23);
    check("dr1_pulse1_off", dcm_reset[1], 1'b0);
    go_to(42);
    check("dr1_before_to2", dcm_reset[1], 1'b0);
    go_to(43);
    check("dr1_pulse2", dcm_reset[1], 1'b1);
    check("retry1_two", retry_count[7:4], 4'd2);
    go_to(46);
    check("dr1_pulse2_off", dcm_reset[1], 1'b0);
    go_to(65);
    check("fault1_before", fault[1], 1'b0);
    go_to(66);
    check("fault1_set", fault[1], 1'b1);
    check("dr1_no_third", dcm_reset[1], 1'b0);
    check("retry1_at_fault", retry_count[7:4], 4'd2);
    check("dr0_still_never", dcm_reset[0], 1'b0);
    go_to(67);
    clear_fault[1] = 1'b1;
    go_to(68);
    clear_fault[1] = 1'b0;
    check("fault1_cleared", fault[1], 1'b0);
    check("retry1_cleared", retry_count[7:4], 4'd0);
    go_to(87);
    check("dr1_before_clr_to", dcm_reset[1], 1'b0);
    go_to(88);
    check("dr1_after_clear", dcm_reset[1], 1'b1);
    check("retry1_after_clear", retry_count[7:4], 4'd1);
    go_to(133);
    check("fault1_again_before", fault[1], 1'b0);
    go_to(134);
    check("fault1_again", fault[1], 1'b1);
    check("all_with_ch1", all_locked_stable, 1'b0);
    channel_enable[1] = 1'b0;
    clear_fault[1] = 1'b1;
    go_to(135);
    clear_fault[1] = 1'b0;
    check("fault1_disabled", fault[1], 1'b0);
    check("retry1_disabled", retry_count[7:4], 4'd0);
    check("all_excl_ch1", all_locked_stable, 1'b1);
    go_to(140);
    dcm_locked[2] = 1'b0;
    go_to(142);
    check("ls2_before_loss", locked_stable[2], 1'b1);
    go_to(143);
    check("ls2_loss", locked_stable[2], 1'b0);
    check("all_lag", all_locked_stable, 1'b1);
    go_to(144);
    check("all_fall", all_locked_stable, 1'b0);
    go_to(162);
    check("dr2_before_to", dcm_reset[2], 1'b0);
    go_to(163);
    check("dr2_to_restart", dcm_reset[2], 1'b1);
    check("retry2_one", retry_count[11:8], 4'd1);
    go_to(164);
    check("dr2_mid_pulse", dcm_reset[2], 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("dr2_async_drop", dcm_reset[2], 1'b0);
    check("outs_async_reset", all_outs(), 32'd0);
    @(posedge input_clk);
    release_reset();
    check("outs_after_rerelease", all_outs(), 32'd0);
    go_to(10);
    check("ls0_relock_before", locked_stable[0], 1'b0);
    go_to(11);
    check("ls0_relock", locked_stable[0], 1'b1);
    check("dr1_disabled", dcm_reset[1], 1'b0);
    go_to(19);
    check("dr2_post_reset_before", dcm_reset[2], 1'b0);
    go_to(20);
    check("dr2_post_reset_to", dcm_reset[2], 1'b1);
    check("retry2_post_reset", retry_count[11:8], 4'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
